s2mm_axi_writer: RTL and testbench
==================================

S2MM_AXI_WRITER -- requirements
Module: s2mm_axi_writer

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 128, meaning the data bus width in bits, which is a power of two and at least 32.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning the byte-address width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 6, meaning the ID width on the AW and B channels.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of buffered write entries, which is a power of two and at least 2.
REQ-005 SHALL have local parameter LSB = clog2(AXI_WIDTH)-3.
REQ-006 SHALL have ports:
clk  in  1  clock; all logic on the rising edge.
rstn  in  1  asynchronous active-low reset.
s2mm_wen  in  1  write-word strobe from the simple-port S2MM side.
s2mm_addr  in  AXI_ADDR_WIDTH-LSB  word address.
s2mm_data  in  AXI_WIDTH  write data.
s2mm_strb  in  AXI_WIDTH/8  byte enables.
m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  AXI_ID_WIDTH/AXI_ADDR_WIDTH/8/3/2/1  AXI4 write-address channel.
m_axi_awready  in  1.
m_axi_wdata/wstrb/wlast/wvalid  out  AXI_WIDTH/AXI_WIDTH/8/1/1  AXI4 write-data channel.
m_axi_wready  in  1.
m_axi_bresp  in  2.
m_axi_bvalid  in  1.
m_axi_bready  out  1.
clr_flags  in  1  synchronous clear of the sticky flags.
busy  out  1  FIFO non-empty or state not IDLE.
overflow  out  1  sticky; a write was dropped.
resp_err  out  1  sticky; a non-OKAY BRESP was received.

Function
REQ-007 SHALL push {s2mm_addr, s2mm_data, s2mm_strb} into the FIFO in the same cycle s2mm_wen is high; the S2MM port has no backpressure.
REQ-008 SHALL drop the entry and set overflow when s2mm_wen is high while the FIFO is full and no pop occurs in that cycle.
REQ-009 SHALL accept a push into a full FIFO when a pop occurs in the same cycle, with no drop and no overflow.
REQ-010 SHALL run an FSM with states IDLE, ISSUE and RESP.
REQ-011 In IDLE with the FIFO non-empty, SHALL pop the head into output registers, assert awvalid and wvalid, and go to ISSUE.
REQ-012 In ISSUE, SHALL deassert awvalid after an awvalid&awready cycle and deassert wvalid after a wvalid&wready cycle, each independently, with the two handshakes allowed in either order or together.
REQ-013 SHALL go from ISSUE to RESP in the cycle after both handshakes complete, and SHALL assert bready only in RESP.
REQ-014 On bvalid&bready, SHALL return to IDLE and set resp_err if bresp is not 2'b00.
REQ-015 SHALL allow at most one outstanding transaction.
REQ-016 SHALL drive the AXI fields as follows:
- awaddr = {addr, LSB zero bits}, truncated to AXI_ADDR_WIDTH.
- awlen = 0, awsize = LSB, awburst = 2'b01, awid = 0, wlast = 1.
REQ-017 SHALL hold all AXI payload outputs stable while the corresponding valid is high.
REQ-018 SHALL issue writes in strict FIFO order.
REQ-019 SHALL have a minimum latency of 1 cycle from a push into an empty FIFO in IDLE to awvalid/wvalid high.
REQ-020 When clr_flags and a new flag event coincide, the flag SHALL be set (event wins).

Reset
REQ-021 On rstn low, asynchronously, SHALL go to IDLE and empty the FIFO.
REQ-022 Under reset, awvalid, wvalid, bready, busy, overflow and resp_err SHALL be 0.
REQ-023 Under reset, the AXI payload registers SHALL be 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction without waiting for B; write data held in the FIFO is lost.

Configuration
REQ-025 With S2MM_AXI_WRITER_ERR_CNT_EN defined, SHALL add output err_count [15:0] that increments on each non-OKAY BRESP.
REQ-026 err_count SHALL saturate at 16'hFFFF, clear on clr_flags, and reset to 0.
REQ-027 Without S2MM_AXI_WRITER_ERR_CNT_EN, the port and its counter SHALL be absent, and behaviour SHALL otherwise be identical.

Verification (AXI_WIDTH=128, FIFO_DEPTH=8)
REQ-028 Single wen with addr=0x10, strb=16'hFFFF, awready/wready/bvalid held high -> one write with awaddr=0x100, awsize=4, awlen=0, wlast=1; busy low again after the B handshake.
REQ-029 wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid is held, RESP is entered only after AW completes, and data is unchanged.
REQ-030 12 back-to-back wen with awready=0 -> 8 entries stored, overflow=1; after release, exactly 8 writes in push order.
REQ-031 bresp=2'b10 on the second of 3 writes -> resp_err=1 and, with the macro, err_count=1; clr_flags -> both 0.
REQ-032 Push while full in the same cycle as a pop -> no overflow, and the entry is written later.
REQ-033 rstn pulsed low while in ISSUE -> all valids 0 immediately, FIFO empty, no further AXI activity.

Source files
------------

// File: rtl/s2mm_axi_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) used by s2mm_axi_writer.
// Modports:
//   master - the writer: drives AW/W payload and valids plus bready; receives the readies and B.
//   slave  - the memory side: the mirror image of master.
interface s2mm_axi_writer_if #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6
);
  logic [AXI_ID_WIDTH-1:0]   awid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_WIDTH-1:0]      wdata;
  logic [AXI_WIDTH/8-1:0]    wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/s2mm_axi_writer.sv
// Buffers single-word writes from a simple S2MM port and issues each as a single-beat
// AXI4 write, one transaction outstanding at a time, in strict arrival order.
// Ports:
//   clk, rstn           - clock (rising edge), asynchronous active-low reset
//   s2mm_wen/addr/data/strb - write strobe, word address, data and byte enables (no backpressure)
//   m_axi               - AXI4 AW/W/B master (s2mm_axi_writer_if.master)
//   clr_flags           - synchronous clear of the sticky flags
//   busy                - FIFO non-empty or a transaction in progress
//   overflow, resp_err  - sticky: a write was dropped / a non-OKAY BRESP arrived
//   err_count           - saturating count of non-OKAY BRESPs; present only when
//                         S2MM_AXI_WRITER_ERR_CNT_EN is defined
module s2mm_axi_writer #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                            clk,
  input  logic                                            rstn,
  input  logic                                            s2mm_wen,
  input  logic [AXI_ADDR_WIDTH-($clog2(AXI_WIDTH)-3)-1:0] s2mm_addr,
  input  logic [AXI_WIDTH-1:0]                            s2mm_data,
  input  logic [AXI_WIDTH/8-1:0]                          s2mm_strb,
  s2mm_axi_writer_if.master                               m_axi,
  input  logic                                            clr_flags,
  output logic                                            busy,
  output logic                                            overflow,
  output logic                                            resp_err
`ifdef S2MM_AXI_WRITER_ERR_CNT_EN
  ,
  output logic [15:0]                                     err_count
`endif
);

  localparam int LSB = $clog2(AXI_WIDTH) - 3;
  localparam int AW  = AXI_ADDR_WIDTH - LSB;
  localparam int SW  = AXI_WIDTH / 8;
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                    state_q;
  logic [AW-1:0]             addr_mem [FIFO_DEPTH];
  logic [AXI_WIDTH-1:0]      data_mem [FIFO_DEPTH];
  logic [SW-1:0]             strb_mem [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [PW:0]               wr_ptr_q, rd_ptr_q;
  logic                      empty, full, pop, push, ovf_evt, err_evt;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_WIDTH-1:0]      wdata_q;
  logic [SW-1:0]             wstrb_q;
  logic                      awvalid_q, wvalid_q, bready_q;
  logic                      overflow_q, resp_err_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop   = (state_q == StIdle) && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push    = s2mm_wen && (!full || pop);
  assign ovf_evt = s2mm_wen && full && !pop;
  assign err_evt = m_axi.bvalid && bready_q && (m_axi.bresp != 2'b00);

  // Storage needs no reset: the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[PW-1:0]] <= s2mm_addr;
      data_mem[wr_ptr_q[PW-1:0]] <= s2mm_data;
      strb_mem[wr_ptr_q[PW-1:0]] <= s2mm_strb;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            awaddr_q  <= {addr_mem[rd_ptr_q[PW-1:0]], {LSB{1'b0}}};
            wdata_q   <= data_mem[rd_ptr_q[PW-1:0]];
            wstrb_q   <= strb_mem[rd_ptr_q[PW-1:0]];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
          // Both channels done once each is either already idle or handshaking now.
          if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
            bready_q <= 1'b1;
            state_q  <= StResp;
          end
        end
        StResp: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Flags: a coincident event beats clr_flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (ovf_evt)        overflow_q <= 1'b1;
      else if (clr_flags) overflow_q <= 1'b0;
      if (err_evt)        resp_err_q <= 1'b1;
      else if (clr_flags) resp_err_q <= 1'b0;
    end
  end

`ifdef S2MM_AXI_WRITER_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_base;

  assign err_count_base = clr_flags ? 16'h0000 : err_count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count_q <= 16'h0000;
    end else if (err_evt && (err_count_base != 16'hFFFF)) begin
      err_count_q <= err_count_base + 16'h0001;
    end else begin
      err_count_q <= err_count_base;
    end
  end

  assign err_count = err_count_q;
`endif

  assign m_axi.awid    = {AXI_ID_WIDTH{1'b0}};
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = 3'(LSB);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  assign busy     = !empty || (state_q != StIdle);
  assign overflow = overflow_q;
  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_s2mm_axi_writer.sv
// Directed self-checking bench for s2mm_axi_writer (AXI_WIDTH=128, FIFO_DEPTH=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_s2mm_axi_writer;
  localparam int AXI_WIDTH      = 128;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 6;
  localparam int FIFO_DEPTH     = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         s2mm_wen = 1'b0;
  logic [27:0]  s2mm_addr = '0;
  logic [127:0] s2mm_data = '0;
  logic [15:0]  s2mm_strb = '0;
  logic         clr_flags = 1'b0;
  logic         busy, overflow, resp_err;
`ifdef S2MM_AXI_WRITER_ERR_CNT_EN
  logic [15:0]  err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int b_cnt = 0;
  int err_idx = -1;
  int base;
  logic [31:0]  aw_q [$];
  logic [127:0] w_q [$];
  logic [15:0]  s_q [$];

  s2mm_axi_writer_if #(
    .AXI_WIDTH(AXI_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_ID_WIDTH(AXI_ID_WIDTH)
  ) m_axi ();

  s2mm_axi_writer #(
    .AXI_WIDTH(AXI_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .AXI_ID_WIDTH(AXI_ID_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s2mm_wen  (s2mm_wen),
    .s2mm_addr (s2mm_addr),
    .s2mm_data (s2mm_data),
    .s2mm_strb (s2mm_strb),
    .m_axi     (m_axi),
    .clr_flags (clr_flags),
    .busy      (busy),
    .overflow  (overflow),
    .resp_err  (resp_err)
`ifdef S2MM_AXI_WRITER_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Slave responds SLVERR on the B handshake numbered err_idx, OKAY otherwise.
  assign m_axi.bresp = (b_cnt == err_idx) ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (m_axi.awvalid && m_axi.awready) aw_q.push_back(m_axi.awaddr);
    if (m_axi.wvalid && m_axi.wready) begin
      w_q.push_back(m_axi.wdata);
      s_q.push_back(m_axi.wstrb);
    end
    if (m_axi.bvalid && m_axi.bready) b_cnt <= b_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int i);
    pat = {4{32'hA500_0000 | 32'(i)}};
  endfunction

  task automatic push_one(input logic [27:0] a, input logic [127:0] d, input logic [15:0] s);
    s2mm_addr = a;
    s2mm_data = d;
    s2mm_strb = s;
    s2mm_wen  = 1'b1;
    step();
    s2mm_wen  = 1'b0;
  endtask

  task automatic set_slave(input logic aw, input logic w, input logic b);
    m_axi.awready = aw;
    m_axi.wready  = w;
    m_axi.bvalid  = b;
  endtask

  task automatic wait_aw(input string tag);
    for (int k = 0; k < 50 && !m_axi.awvalid; k++) step();
    check_eq(tag, m_axi.awvalid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 300 && busy; k++) step();
    check_eq(tag, busy, 1'b0);
  endtask

  initial begin
    set_slave(1'b0, 1'b0, 1'b0);
    step();
    step();
    // Reset state
    check_eq("rst_awvalid", m_axi.awvalid, 1'b0);
    check_eq("rst_wvalid", m_axi.wvalid, 1'b0);
    check_eq("rst_bready", m_axi.bready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_resp_err", resp_err, 1'b0);
    check_eq("rst_awaddr", m_axi.awaddr, 32'h0);
    check_eq("rst_wdata", m_axi.wdata, 128'h0);
`ifdef S2MM_AXI_WRITER_ERR_CNT_EN
    check_eq("rst_err_count", err_count, 16'h0);
`endif
    #3 rstn = 1'b1;
    step();

    // Single write with everything ready
    set_slave(1'b1, 1'b1, 1'b1);
    push_one(28'h10, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF);
    check_eq("t1_busy_after_push", busy, 1'b1);
    check_eq("t1_awvalid_not_yet", m_axi.awvalid, 1'b0);
    step();
    check_eq("t1_awvalid", m_axi.awvalid, 1'b1);
    check_eq("t1_wvalid", m_axi.wvalid, 1'b1);
    check_eq("t1_awaddr", m_axi.awaddr, 32'h100);
    check_eq("t1_awsize", m_axi.awsize, 3'd4);
    check_eq("t1_awlen", m_axi.awlen, 8'd0);
    check_eq("t1_awburst", m_axi.awburst, 2'b01);
    check_eq("t1_awid", m_axi.awid, 6'd0);
    check_eq("t1_wlast", m_axi.wlast, 1'b1);
    check_eq("t1_wdata", m_axi.wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check_eq("t1_wstrb", m_axi.wstrb, 16'hFFFF);
    step();
    check_eq("t1_awvalid_drop", m_axi.awvalid, 1'b0);
    check_eq("t1_wvalid_drop", m_axi.wvalid, 1'b0);
    check_eq("t1_bready", m_axi.bready, 1'b1);
    step();
    check_eq("t1_bready_drop", m_axi.bready, 1'b0);
    check_eq("t1_busy_done", busy, 1'b0);
    check_eq("t1_aw_count", aw_q.size(), 1);

    // W handshake three cycles before AW
    set_slave(1'b0, 1'b0, 1'b0);
    base = aw_q.size();
    push_one(28'h20, pat(99), 16'h0F0F);
    step();
    check_eq("t2_awvalid", m_axi.awvalid, 1'b1);
    m_axi.wready = 1'b1;
    step();
    m_axi.wready = 1'b0;
    check_eq("t2_wvalid_drop", m_axi.wvalid, 1'b0);
    check_eq("t2_awvalid_held", m_axi.awvalid, 1'b1);
    check_eq("t2_no_bready", m_axi.bready, 1'b0);
    step();
    step();
    check_eq("t2_awvalid_still", m_axi.awvalid, 1'b1);
    check_eq("t2_no_bready_still", m_axi.bready, 1'b0);
    check_eq("t2_awaddr_stable", m_axi.awaddr, 32'h200);
    m_axi.awready = 1'b1;
    step();
    m_axi.awready = 1'b0;
    check_eq("t2_awvalid_drop", m_axi.awvalid, 1'b0);
    check_eq("t2_bready", m_axi.bready, 1'b1);
    m_axi.bvalid = 1'b1;
    step();
    m_axi.bvalid = 1'b0;
    check_eq("t2_busy_done", busy, 1'b0);
    check_eq("t2_aw_count", aw_q.size() - base, 1);
    check_eq("t2_wdata", w_q[w_q.size()-1], pat(99));
    check_eq("t2_wstrb", s_q[s_q.size()-1], 16'h0F0F);

    // Overflow: one in flight, 12 pushes, 8 kept
    set_slave(1'b0, 1'b0, 1'b0);
    base = aw_q.size();
    push_one(28'h300, pat(300), 16'hFFFF);
    wait_aw("t3_blocker_issued");
    for (int i = 0; i < 12; i++) begin
      s2mm_addr = 28'h400 + 28'(i);
      s2mm_data = pat(i);
      s2mm_strb = 16'h1 << i;
      s2mm_wen  = 1'b1;
      step();
    end
    s2mm_wen = 1'b0;
    check_eq("t3_overflow", overflow, 1'b1);
    set_slave(1'b1, 1'b1, 1'b1);
    wait_idle("t3_drain");
    check_eq("t3_aw_count", aw_q.size() - base, 9);
    check_eq("t3_blocker_addr", aw_q[base], 32'h3000);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t3_addr%0d", i), aw_q[base+1+i], 32'h4000 + 32'(i * 16));
      check_eq($sformatf("t3_data%0d", i), w_q[base+1+i], pat(i));
    end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check_eq("t3_overflow_clr", overflow, 1'b0);

    // Push into a full FIFO in the same cycle as a pop
    set_slave(1'b0, 1'b0, 1'b0);
    base = aw_q.size();
    push_one(28'h4FF, pat(400), 16'hFFFF);
    wait_aw("t4_blocker_issued");
    for (int i = 0; i < 8; i++) push_one(28'h500 + 28'(i), pat(500 + i), 16'hFFFF);
    check_eq("t4_full_no_ovf", overflow, 1'b0);
    m_axi.awready = 1'b1;
    m_axi.wready  = 1'b1;
    for (int k = 0; k < 10 && !m_axi.bready; k++) step();
    check_eq("t4_in_resp", m_axi.bready, 1'b1);
    m_axi.awready = 1'b0;
    m_axi.wready  = 1'b0;
    m_axi.bvalid  = 1'b1;
    step();
    m_axi.bvalid = 1'b0;
    check_eq("t4_back_idle", m_axi.bready, 1'b0);
    push_one(28'h5FF, pat(599), 16'hAAAA);
    check_eq("t4_no_overflow", overflow, 1'b0);
    set_slave(1'b1, 1'b1, 1'b1);
    wait_idle("t4_drain");
    check_eq("t4_aw_count", aw_q.size() - base, 10);
    check_eq("t4_last_full_addr", aw_q[base+8], 32'h5070);
    check_eq("t4_extra_addr", aw_q[base+9], 32'h5FF0);
    check_eq("t4_extra_data", w_q[base+9], pat(599));

    // SLVERR on the second of three writes
    err_idx = b_cnt + 1;
    for (int i = 0; i < 3; i++) begin
      s2mm_addr = 28'h600 + 28'(i);
      s2mm_data = pat(600 + i);
      s2mm_strb = 16'hFFFF;
      s2mm_wen  = 1'b1;
      step();
    end
    s2mm_wen = 1'b0;
    wait_idle("t5_drain");
    check_eq("t5_resp_err", resp_err, 1'b1);
    check_eq("t5_overflow", overflow, 1'b0);
`ifdef S2MM_AXI_WRITER_ERR_CNT_EN
    check_eq("t5_err_count", err_count, 16'd1);
`endif
    err_idx = -1;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check_eq("t5_resp_err_clr", resp_err, 1'b0);
`ifdef S2MM_AXI_WRITER_ERR_CNT_EN
    check_eq("t5_err_count_clr", err_count, 16'd0);
`endif

    // Reset in the middle of a transaction
    set_slave(1'b0, 1'b0, 1'b0);
    base = aw_q.size();
    for (int i = 0; i < 3; i++) push_one(28'h700 + 28'(i), pat(700 + i), 16'hFFFF);
    wait_aw("t6_issued");
    rstn = 1'b0;
    #1;
    check_eq("t6_awvalid_rst", m_axi.awvalid, 1'b0);
    check_eq("t6_wvalid_rst", m_axi.wvalid, 1'b0);
    check_eq("t6_busy_rst", busy, 1'b0);
    check_eq("t6_awaddr_rst", m_axi.awaddr, 32'h0);
    #2 rstn = 1'b1;
    set_slave(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step();
    check_eq("t6_no_activity", aw_q.size() - base, 0);
    check_eq("t6_awvalid_idle", m_axi.awvalid, 1'b0);
    check_eq("t6_busy_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
